// File: rtl/map_pkg.sv
// Shared constants for the tile-map playfield renderer: tile codes,
// palette, screen geometry and the menu button rectangle.
package map_pkg;

    typedef enum logic [2:0] {
        TILE_GROUND   = 3'd0,
        TILE_WALL     = 3'd1,
        TILE_ROCK     = 3'd2,
        TILE_BUILDING = 3'd3,
        TILE_TRACK    = 3'd4,
        TILE_DAMAGED  = 3'd5
    } tile_e;

    localparam logic [11:0] RGB_GROUND   = 12'hEC1;
    localparam logic [11:0] RGB_WALL     = 12'hDA0;
    localparam logic [11:0] RGB_ROCK     = 12'h89F;
    localparam logic [11:0] RGB_BUILDING = 12'h777;
    localparam logic [11:0] RGB_TRACK    = 12'h512;
    localparam logic [11:0] RGB_DAMAGED  = 12'h960;
    localparam logic [11:0] RGB_BLACK    = 12'h000;
    localparam logic [11:0] BORDER       = 12'hFFF;
    localparam logic [11:0] PANEL        = 12'h888;
    localparam logic [11:0] BUTTON_ON    = 12'hC12;

    // Last visible pixel of the 1024x768 screen.
    localparam logic [10:0] H_LAST = 11'd1023;
    localparam logic [9:0]  V_LAST = 10'd767;

    localparam logic [10:0] BTN_X0 = 11'd993;
    localparam logic [10:0] BTN_X1 = 11'd1013;
    localparam logic [9:0]  BTN_Y0 = 10'd10;
    localparam logic [9:0]  BTN_Y1 = 10'd30;

    // Video position plus timing strobes, carried down the pipeline as one word.
    typedef struct packed {
        logic [10:0] hcount;
        logic [9:0]  vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vid_t;

    // Tile type to colour; codes without a palette entry render black.
    function automatic logic [11:0] tile_rgb(input logic [7:0] t);
        case (t)
            8'(TILE_GROUND):   tile_rgb = RGB_GROUND;
            8'(TILE_WALL):     tile_rgb = RGB_WALL;
            8'(TILE_ROCK):     tile_rgb = RGB_ROCK;
            8'(TILE_BUILDING): tile_rgb = RGB_BUILDING;
            8'(TILE_TRACK):    tile_rgb = RGB_TRACK;
            8'(TILE_DAMAGED):  tile_rgb = RGB_DAMAGED;
            default:           tile_rgb = RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/draw_map_tiles_if.sv
// Tile-map write port: valid/ready handshake plus out-of-range error pulse.
interface draw_map_tiles_if #(
    parameter int COL_W  = 5,
    parameter int ROW_W  = 5,
    parameter int TYPE_W = 3
);
    logic              wr_valid;
    logic              wr_ready;
    logic [COL_W-1:0]  wr_col;
    logic [ROW_W-1:0]  wr_row;
    logic [TYPE_W-1:0] wr_type;
    logic              wr_err;

    modport master (output wr_valid, wr_col, wr_row, wr_type, input wr_ready, wr_err);
    modport slave  (input wr_valid, wr_col, wr_row, wr_type, output wr_ready, wr_err);
endinterface

// File: rtl/map_tile_ram.sv
// Simple dual-port tile RAM: one write port, one synchronous read-first read port.
module map_tile_ram #(
    parameter int DEPTH  = 576,
    parameter int WIDTH  = 3,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata_q
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Both ports use non-blocking updates, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end
endmodule

// File: rtl/draw_map_tiles.sv
// Tile-map playfield renderer: frame, tile playfield from RAM, side panel
// and blinking menu button. Two-cycle pixel pipeline; RAM cleared after reset.
module draw_map_tiles
    import map_pkg::*;
#(
    parameter int TILE_LOG2    = 5,
    parameter int MAP_COLS     = 24,
    parameter int MAP_ROWS     = 24,
    parameter int TYPE_W       = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        init_done,
    draw_map_tiles_if.slave wr
);
    localparam int DEPTH  = MAP_COLS * MAP_ROWS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int FCNT_W = $clog2(BLINK_FRAMES);
    localparam logic [10:0] PF_W = 11'(MAP_COLS << TILE_LOG2);
    localparam logic [9:0]  PF_H = 10'(MAP_ROWS << TILE_LOG2);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_err_q, wr_err_d;
    logic              vblnk_prev_q, vblnk_prev_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic              blink_q, blink_d;
    vid_t              s1_vid_q, s1_vid_d, s2_vid_q, s2_vid_d;
    logic              s1_blank_q, s1_blank_d, s1_frame_q, s1_frame_d;
    logic              s1_pf_q, s1_pf_d, s1_btn_q, s1_btn_d, s1_init_q, s1_init_d;
    logic [11:0]       rgb_q, rgb_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr, pix_addr;
    logic [TYPE_W-1:0] ram_wdata, ram_rdata;
    logic              in_pf, wr_fire, wr_in_range;

    assign wr.wr_ready = (state_q == ST_RUN);
    assign init_done   = (state_q == ST_RUN);
    assign wr.wr_err   = wr_err_q;
    assign wr_fire     = wr.wr_valid && wr.wr_ready;
    assign wr_in_range = (32'(wr.wr_col) < MAP_COLS) && (32'(wr.wr_row) < MAP_ROWS);

    // Clear sweep after reset, then accept tile writes; out-of-range writes are dropped.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_err_d  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = cnt_q;
        ram_wdata = '0;
        case (state_q)
            ST_INIT: begin
                ram_we = 1'b1;
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (wr_fire) begin
                    if (wr_in_range) begin
                        ram_we    = 1'b1;
                        ram_waddr = ADDR_W'(32'(wr.wr_row) * MAP_COLS + 32'(wr.wr_col));
                        ram_wdata = wr.wr_type;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Button blink: count vblank rising edges, toggle every BLINK_FRAMES of them.
    always_comb begin
        vblnk_prev_d = vblnk_in;
        frame_cnt_d  = frame_cnt_q;
        blink_d      = blink_q;
        if (vblnk_in && !vblnk_prev_q) begin
            if (frame_cnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Stage 0 decode: tile address and screen regions for the incoming pixel.
    always_comb begin
        in_pf    = (hcount_in < PF_W) && (vcount_in < PF_H);
        pix_addr = in_pf ? ADDR_W'(32'(vcount_in >> TILE_LOG2) * MAP_COLS
                                   + 32'(hcount_in >> TILE_LOG2)) : '0;
        s1_vid_d   = '{hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
        s1_blank_d = hblnk_in || vblnk_in;
        s1_frame_d = (vcount_in <= 10'd1) || (vcount_in >= V_LAST - 10'd1) ||
                     (hcount_in <= 11'd1) || (hcount_in == H_LAST) ||
                     (hcount_in == PF_W) || (hcount_in == PF_W + 11'd1);
        s1_pf_d    = in_pf;
        s1_btn_d   = (vcount_in >= BTN_Y0) && (vcount_in <= BTN_Y1) &&
                     (hcount_in >= BTN_X0) && (hcount_in <= BTN_X1);
        // Until the clear finishes the RAM may hold stale tiles, so draw ground.
        s1_init_d  = (state_q == ST_INIT);
    end

    // Stage 1 colour selection in priority order.
    always_comb begin
        s2_vid_d = s1_vid_q;
        if (s1_blank_q)      rgb_d = RGB_BLACK;
        else if (s1_frame_q) rgb_d = BORDER;
        else if (s1_pf_q)    rgb_d = s1_init_q ? RGB_GROUND : tile_rgb(8'(ram_rdata));
        else if (s1_btn_q)   rgb_d = blink_q ? BUTTON_ON : PANEL;
        else                 rgb_d = PANEL;
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            wr_err_q     <= 1'b0;
            vblnk_prev_q <= 1'b0;
            frame_cnt_q  <= '0;
            blink_q      <= 1'b1;
            s1_vid_q     <= '0;
            s2_vid_q     <= '0;
            s1_blank_q   <= 1'b0;
            s1_frame_q   <= 1'b0;
            s1_pf_q      <= 1'b0;
            s1_btn_q     <= 1'b0;
            s1_init_q    <= 1'b0;
            rgb_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_err_q     <= wr_err_d;
            vblnk_prev_q <= vblnk_prev_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
            s1_vid_q     <= s1_vid_d;
            s2_vid_q     <= s2_vid_d;
            s1_blank_q   <= s1_blank_d;
            s1_frame_q   <= s1_frame_d;
            s1_pf_q      <= s1_pf_d;
            s1_btn_q     <= s1_btn_d;
            s1_init_q    <= s1_init_d;
            rgb_q        <= rgb_d;
        end
    end

    map_tile_ram #(.DEPTH(DEPTH), .WIDTH(TYPE_W), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr   (pix_addr),
        .rdata_q (ram_rdata)
    );

    assign hcount_out = s2_vid_q.hcount;
    assign vcount_out = s2_vid_q.vcount;
    assign hsync_out  = s2_vid_q.hsync;
    assign vsync_out  = s2_vid_q.vsync;
    assign hblnk_out  = s2_vid_q.hblnk;
    assign vblnk_out  = s2_vid_q.vblnk;
    assign rgb_out    = rgb_q;
endmodule

// File: doc/draw_map_tiles.md
# draw_map_tiles

Tile-map playfield renderer: the parametrised successor to the fixed-geometry map drawer. It replaces hard-coded rectangles with a writable tile-map RAM, so game logic can change terrain at run time (walls destroyed, craters added). It sits in the video chain after the timing generator and before the sprite/tank overlay stages. It draws the 2 px white frame, the tile playfield, the grey side panel and a blinking menu button.

## Interface
- TILE_LOG2, 5: tile edge = 2^TILE_LOG2 px (32).
- MAP_COLS, 24: tiles per row; playfield width = MAP_COLS<<TILE_LOG2.
- MAP_ROWS, 24: tile rows.
- TYPE_W, 3: tile type code width.
- BLINK_FRAMES, 30: frames per button blink half-period.
- clk  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-high.
- hcount_in  in  11  pixel column.
- vcount_in  in  10  pixel row.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing strobes.
- hcount_out  out  11  hcount delayed 2 cycles.
- vcount_out  out  10  vcount delayed 2 cycles.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  strobes delayed 2 cycles.
- rgb_out  out  12  pixel colour, 4:4:4.
- wr_valid  in  1  tile write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_col  in  $clog2(MAP_COLS)  target column.
- wr_row  in  $clog2(MAP_ROWS)  target row.
- wr_type  in  TYPE_W  new tile type.
- wr_err  out  1  one-cycle pulse: accepted write was out of range and dropped.
- init_done  out  1  high once map clear is complete.

## Operation
- FSM states:
  - INIT (after reset): clears the RAM by writing type 0 to addresses 0..MAP_COLS*MAP_ROWS-1, one per cycle. wr_ready=0. Playfield pixels are drawn as ground.
  - After the last address: RUN. init_done=1, wr_ready=1.
  - rst in any state returns to INIT with the counter at 0 and restarts the clear.
- Address = row*MAP_COLS + col. Pixel col = hcount>>TILE_LOG2, row = vcount>>TILE_LOG2.
- Writes (RUN only): handshake on wr_valid & wr_ready. If wr_col >= MAP_COLS or wr_row >= MAP_ROWS, the RAM is unchanged and wr_err pulses on the next cycle. One write per cycle is sustained.
- RAM is read-first. A write to the address being read returns the old type that cycle.
- Colour priority (highest first):
  - blanking -> 0x000
  - frame lines (v 0–1, v 766–767, h 0–1, h 1023, and the 2 px column right of the playfield) -> 0xFFF
  - playfield tile palette: 0 ground 0xEC1, 1 wall 0xDA0, 2 rock 0x89F, 3 building 0x777, 4 track 0x512, 5 damaged wall 0x960, 6/7 -> 0x000
  - button (v 10–30, h 993–1013) -> 0xC12 when blink=1, else 0x888
  - panel -> 0x888
- Blink: frame counter increments on each vblnk_in rising edge. When it reaches BLINK_FRAMES-1 it wraps to 0 and toggles blink. Reset: blink=1, counter 0.

## Timing
- Latency 2 cycles, position in to rgb_out:
  - Stage 0 registers position and strobes and computes the address.
  - Stage 1 holds the RAM read data and the region decode.
  - Stage 2 registers rgb_out.
- Every output is aligned with its strobes.
- Reset values:
  - rgb_out 0, all delayed strobes and counts 0.
  - wr_ready 0, wr_err 0, init_done 0.
- INIT duration is exactly MAP_COLS*MAP_ROWS cycles after rst deasserts. init_done rises on the next edge.
- A write accepted at edge N is visible to a read issued at edge N+1 or later.

## Structure
- Package map_pkg holds:
  - tile type codes (TILE_GROUND … TILE_DAMAGED)
  - palette constants
  - BORDER and PANEL colours
  - button rectangle bounds
- Sub-module map_tile_ram: simple dual-port RAM (one write, one sync read, read-first), depth MAP_COLS*MAP_ROWS, width TYPE_W.

## Test plan
- Reset, then count cycles: init_done rises after 576 cycles. All playfield pixels are 0xEC1 before and after.
- Write col 3, row 2, type 1 in RUN. Pixel (h 100, v 70) reads 0xDA0, 2 cycles after it is presented. Neighbour (h 128, v 70) stays 0xEC1.
- Write col 24, row 0. wr_err pulses one cycle and the RAM is unchanged (full readback scan matches).
- Assert rst mid-INIT (cycle 200), then mid-RUN after writes. INIT restarts from 0 and all tiles read type 0 afterwards.
- Toggle vblnk for 60 frames. Button pixel (1000, 20) alternates 0xC12/0x888 every 30 frames. hblnk pixel is 0x000.
- Write the address under the current scan pixel in the same cycle. That pixel shows the old colour and the next frame shows the new one.
